// File: rtl/i_buf_controller_pkg.sv
// -----------------------------------------------------------------------------
// i_buf_controller_pkg
// Shared definitions for the capture-side linebuffer controller: default video
// geometry, word packing constants, FSM state encoding and the byte-lane helper
// used by the pixel packer. The output-side controller uses the same byte-lane
// ordering, so a word written here reads back identically there.
// -----------------------------------------------------------------------------
package i_buf_controller_pkg;

  // Default geometry (overridable per instance)
  localparam int DEF_ADDRESS_WIDTH  = 32;
  localparam int DEF_DISPLAY_WIDTH  = 640;
  localparam int DEF_DISPLAY_HEIGHT = 480;

  // Porch defaults kept alongside the active area for the shared video setup
  localparam int DEF_H_FRONT_PORCH  = 16;
  localparam int DEF_H_SYNC_WIDTH   = 96;
  localparam int DEF_H_BACK_PORCH   = 48;
  localparam int DEF_V_FRONT_PORCH  = 10;
  localparam int DEF_V_SYNC_WIDTH   = 2;
  localparam int DEF_V_BACK_PORCH   = 33;

  // Packing: four RAW8 pixels per 32-bit linebuffer word
  localparam int PIX_PER_WORD = 4;
  localparam int PIX_W        = 8;
  localparam int WORD_W       = 32;

  // Pixel and line counters are 13 bits wide
  localparam int CNT_W = 13;

  // Capture FSM states
  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    WAIT_LINE  = 2'd1,
    ACTIVE     = 2'd2,
    FLUSH      = 2'd3
  } state_e;

  // Insert one pixel into byte lane 'lane'; lane 0 is the MSB byte, so the
  // first pixel of a group of four lands in bits [31:24].
  function automatic logic [31:0] set_byte_lane(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic [7:0]  px
  );
    logic [31:0] w;
    w = word;
    case (lane)
      2'd0:    w[31:24] = px;
      2'd1:    w[23:16] = px;
      2'd2:    w[15:8]  = px;
      2'd3:    w[7:0]   = px;
      default: w[31:24] = px;
    endcase
    return w;
  endfunction

  // Number of linebuffer words needed for one line of 'width' pixels
  function automatic int line_words(input int width);
    return (width + PIX_PER_WORD - 1) / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/i_buf_controller_pix_packer.sv
// -----------------------------------------------------------------------------
// i_buf_controller_pix_packer
// Packs RAW8 pixels into 32-bit words, first pixel in the MSB byte.
// A push into lane 0 starts a fresh word, so the unused low bytes of a partial
// word are always zero when it is flushed.
// Ports:
//   pclk     in   pixel clock
//   reset_n  in   synchronous reset, active-low
//   clear_i  in   drop any partially packed word and return to lane 0
//   push_i   in   accept data_i into the next byte lane
//   data_i   in   pixel value
//   word_o   out  word under assembly (complete word while full_o is high)
//   cnt_o    out  bytes held in the current partial word (0 = none)
//   full_o   out  1-cycle flag: word_o holds a complete 4-pixel word
// -----------------------------------------------------------------------------
module i_buf_controller_pix_packer
  import i_buf_controller_pkg::*;
(
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic [1:0]  cnt_o,
  output logic        full_o
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        full_q;
  logic [31:0] word_base_s;

  // Lane 0 starts a new word from zero instead of the previous contents
  always_comb begin
    word_base_s = 32'h0000_0000;
    if (cnt_q == 2'd0) begin
      word_base_s = 32'h0000_0000;
    end else begin
      word_base_s = word_q;
    end
  end

  // Byte-lane shift/pack register with completion flag
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      word_q <= 32'h0000_0000;
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      word_q <= 32'h0000_0000;
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
    end else if (push_i) begin
      word_q <= set_byte_lane(word_base_s, cnt_q, data_i);
      cnt_q  <= cnt_q + 2'd1;
      full_q <= (cnt_q == 2'd3);
    end else begin
      full_q <= 1'b0;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;
  assign full_o = full_q;

endmodule

// File: rtl/i_buf_controller.sv
// -----------------------------------------------------------------------------
// i_buf_controller
// Video capture front end. Samples a pclk-synchronous RAW8 stream, packs four
// pixels per 32-bit word and writes them into a ping-pong linebuffer. Bank b
// occupies words [b*LINE_WORDS, (b+1)*LINE_WORDS-1]. Each completed line is
// announced with a line_ready pulse so software can move it to the
// framebuffer; the last line of a frame also pulses frame_done.
// Ports:
//   pclk        in   pixel clock, all logic on rising edge
//   reset_n     in   synchronous reset, active-low
//   vsync       in   vertical sync, active-low; falling edge starts a frame
//   hsync       in   horizontal sync, active-low; lines are framed by vde
//   vde         in   video data enable, high on active pixels
//   i_data      in   RAW8 pixel, valid when vde=1
//   addr        out  linebuffer word address
//   o_data      out  packed pixel word
//   wr_en       out  write strobe, one word per pulse
//   line_ready  out  1-cycle pulse: line complete in ready_bank
//   ready_bank  out  bank of the last completed line
//   line_num    out  index of the last completed line
//   frame_done  out  1-cycle pulse together with the last line's line_ready
//   err_len     out  sticky line-length / aborted-line error
// -----------------------------------------------------------------------------
module i_buf_controller
  import i_buf_controller_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT
) (
  input  logic                     pclk,
  input  logic                     reset_n,
  input  logic                     vsync,
  input  logic                     hsync,
  input  logic                     vde,
  input  logic [7:0]               i_data,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [31:0]              o_data,
  output logic                     wr_en,
  output logic                     line_ready,
  output logic                     ready_bank,
  output logic [12:0]              line_num,
  output logic                     frame_done,
  output logic                     err_len
);

  localparam int                     LINE_WORDS = line_words(DISPLAY_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] BANK1_BASE = ADDRESS_WIDTH'(LINE_WORDS);
  localparam logic [CNT_W-1:0]       PIX_MAX    = CNT_W'(DISPLAY_WIDTH);
  localparam logic [CNT_W-1:0]       LAST_LINE  = CNT_W'(DISPLAY_HEIGHT - 1);

  // FSM and counters
  state_e                   state_q;
  logic                     vsync_prev_q;
  logic                     hsync_unused_q;
  logic                     bank_q;
  logic [CNT_W-1:0]         pix_cnt_q;
  logic [CNT_W-1:0]         line_cnt_q;

  // Registered outputs
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              o_data_q;
  logic                     wr_en_q;
  logic                     line_ready_q;
  logic                     ready_bank_q;
  logic [12:0]              line_num_q;
  logic                     frame_done_q;
  logic                     err_len_q;

  // Packer interface
  logic                     push_s;
  logic                     clear_s;
  logic [31:0]              word_s;
  logic [1:0]               pend_cnt_s;
  logic                     full_s;

  // Address helpers
  logic                     vsync_fall_s;
  logic [ADDRESS_WIDTH-1:0] base_s;
  logic [ADDRESS_WIDTH-1:0] full_addr_s;
  logic [ADDRESS_WIDTH-1:0] part_addr_s;

  assign vsync_fall_s = vsync_prev_q & ~vsync;

  // Word addresses. A full word is written the cycle after its 4th pixel, when
  // pix_cnt already counts that pixel, hence the -1. A partial word sits at
  // floor(pix_cnt/4).
  always_comb begin
    base_s = {ADDRESS_WIDTH{1'b0}};
    if (bank_q) begin
      base_s = BANK1_BASE;
    end else begin
      base_s = {ADDRESS_WIDTH{1'b0}};
    end
    full_addr_s = base_s + ADDRESS_WIDTH'((pix_cnt_q >> 2'd2) - 13'd1);
    part_addr_s = base_s + ADDRESS_WIDTH'(pix_cnt_q >> 2'd2);
  end

  // Packer control: push accepted pixels, clear whenever a line ends or aborts
  always_comb begin
    push_s  = 1'b0;
    clear_s = 1'b0;
    case (state_q)
      WAIT_FRAME: begin
        clear_s = 1'b1;
      end
      WAIT_LINE: begin
        if (vsync_fall_s) begin
          clear_s = 1'b1;
        end else if (vde) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ACTIVE: begin
        if (vsync_fall_s) begin
          clear_s = 1'b1;
        end else if (vde && (pix_cnt_q < PIX_MAX)) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      FLUSH: begin
        clear_s = 1'b1;
      end
      default: begin
        clear_s = 1'b1;
      end
    endcase
  end

  i_buf_controller_pix_packer u_packer (
    .pclk    (pclk),
    .reset_n (reset_n),
    .clear_i (clear_s),
    .push_i  (push_s),
    .data_i  (i_data),
    .word_o  (word_s),
    .cnt_o   (pend_cnt_s),
    .full_o  (full_s)
  );

  // Capture FSM, counters and registered outputs
  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state_q        <= WAIT_FRAME;
      vsync_prev_q   <= 1'b0;
      hsync_unused_q <= 1'b0;
      bank_q         <= 1'b0;
      pix_cnt_q      <= 13'd0;
      line_cnt_q     <= 13'd0;
      addr_q         <= {ADDRESS_WIDTH{1'b0}};
      o_data_q       <= 32'h0000_0000;
      wr_en_q        <= 1'b0;
      line_ready_q   <= 1'b0;
      ready_bank_q   <= 1'b0;
      line_num_q     <= 13'd0;
      frame_done_q   <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      vsync_prev_q   <= vsync;
      hsync_unused_q <= hsync;
      wr_en_q        <= 1'b0;
      line_ready_q   <= 1'b0;
      frame_done_q   <= 1'b0;

      // A word completed on the previous edge is written now, whatever the
      // state; it was complete before any abort could discard it.
      if (full_s) begin
        wr_en_q  <= 1'b1;
        o_data_q <= word_s;
        addr_q   <= full_addr_s;
      end

      case (state_q)
        WAIT_FRAME: begin
          if (vsync_fall_s) begin
            state_q    <= WAIT_LINE;
            line_cnt_q <= 13'd0;
            bank_q     <= 1'b0;
            pix_cnt_q  <= 13'd0;
          end
        end
        WAIT_LINE: begin
          if (vsync_fall_s) begin
            line_cnt_q <= 13'd0;
            bank_q     <= 1'b0;
            pix_cnt_q  <= 13'd0;
          end else if (vde) begin
            state_q   <= ACTIVE;
            pix_cnt_q <= 13'd1;
          end
        end
        ACTIVE: begin
          if (vsync_fall_s) begin
            // Abort: pending partial word is dropped by the packer clear
            state_q    <= WAIT_LINE;
            line_cnt_q <= 13'd0;
            bank_q     <= 1'b0;
            pix_cnt_q  <= 13'd0;
            err_len_q  <= 1'b1;
          end else if (vde) begin
            if (pix_cnt_q < PIX_MAX) begin
              pix_cnt_q <= pix_cnt_q + 13'd1;
            end else begin
              err_len_q <= 1'b1;
            end
          end else begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (pend_cnt_s != 2'd0) begin
            wr_en_q  <= 1'b1;
            o_data_q <= word_s;
            addr_q   <= part_addr_s;
          end
          if (pix_cnt_q != PIX_MAX) begin
            err_len_q <= 1'b1;
          end
          line_ready_q <= 1'b1;
          ready_bank_q <= bank_q;
          line_num_q   <= line_cnt_q;
          bank_q       <= ~bank_q;
          line_cnt_q   <= line_cnt_q + 13'd1;
          pix_cnt_q    <= 13'd0;
          if (line_cnt_q == LAST_LINE) begin
            frame_done_q <= 1'b1;
            state_q      <= WAIT_FRAME;
          end else begin
            state_q <= WAIT_LINE;
          end
        end
        default: begin
          state_q <= WAIT_FRAME;
        end
      endcase
    end
  end

  // hsync is sampled for pin parity with the output side only
  logic unused_s;
  assign unused_s = hsync_unused_q;

  assign addr       = addr_q;
  assign o_data     = o_data_q;
  assign wr_en      = wr_en_q;
  assign line_ready = line_ready_q;
  assign ready_bank = ready_bank_q;
  assign line_num   = line_num_q;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;

endmodule

// File: tb/tb_i_buf_controller.sv
module tb_i_buf_controller;

  localparam int DW = 8;
  localparam int DH = 2;
  localparam int LW = (DW + 3) / 4;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vsync = 1'b1;
  logic        hsync = 1'b1;
  logic        vde = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic [31:0] addr;
  logic [31:0] o_data;
  logic        wr_en;
  logic        line_ready;
  logic        ready_bank;
  logic [12:0] line_num;
  logic        frame_done;
  logic        err_len;

  always #5 pclk = ~pclk;

  i_buf_controller #(
    .ADDRESS_WIDTH  (32),
    .DISPLAY_WIDTH  (DW),
    .DISPLAY_HEIGHT (DH)
  ) dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .hsync      (hsync),
    .vde        (vde),
    .i_data     (i_data),
    .addr       (addr),
    .o_data     (o_data),
    .wr_en      (wr_en),
    .line_ready (line_ready),
    .ready_bank (ready_bank),
    .line_num   (line_num),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic b; logic [12:0] n; logic fd; } ln_t;

  wr_t wr_q[$];
  ln_t ln_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  // Reference model: frame state as plain integers
  bit  mdl_in_frame = 1'b0;
  int  mdl_line = 0;
  bit  mdl_err = 1'b0;
  logic [7:0] pix [0:15];

  // Monitor's view of held line status
  logic        exp_bank = 1'b0;
  logic [12:0] exp_num = 13'd0;
  wr_t         mw;
  ln_t         ml;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Expected linebuffer traffic for one line of n pixels (m >= 0: vsync aborts after m pixels)
  task automatic model_line(input int n, input int m);
    int cnt, kept, nw;
    logic [31:0] d;
    wr_t w;
    ln_t l;
    if (m >= 0) begin
      if (mdl_in_frame) begin
        kept = (m < DW) ? m : DW;
        nw = kept / 4;
        for (int wi = 0; wi < nw; wi++) begin
          d = 32'h0;
          for (int b = 0; b < 4; b++) d = d | (32'(pix[4*wi+b]) << (24 - 8*b));
          w.a = 32'((mdl_line % 2) * LW + wi);
          w.d = d;
          wr_q.push_back(w);
        end
        mdl_err = 1'b1;
      end
      mdl_in_frame = 1'b1;
      mdl_line = 0;
      return;
    end
    if (!mdl_in_frame) return;
    cnt = n;
    kept = (cnt < DW) ? cnt : DW;
    nw = (kept + 3) / 4;
    for (int wi = 0; wi < nw; wi++) begin
      d = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4*wi + b < kept) d = d | (32'(pix[4*wi+b]) << (24 - 8*b));
      w.a = 32'((mdl_line % 2) * LW + wi);
      w.d = d;
      wr_q.push_back(w);
    end
    l.b  = 1'(mdl_line % 2);
    l.n  = 13'(mdl_line);
    l.fd = (mdl_line == DH - 1);
    ln_q.push_back(l);
    if (n != DW) mdl_err = 1'b1;
    mdl_line++;
    if (mdl_line == DH) mdl_in_frame = 1'b0;
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents output
  always @(negedge pclk) begin
    if (!reset_n) begin
      exp_bank = 1'b0;
      exp_num  = 13'd0;
    end else begin
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", addr, o_data);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", addr, mw.a);
          chk("wr_data", o_data, mw.d);
        end
      end
      if (line_ready) begin
        if (ln_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_line_ready: got line_num %0d expected none", line_num);
        end else begin
          ml = ln_q.pop_front();
          chk("ready_bank", 32'(ready_bank), 32'(ml.b));
          chk("line_num", 32'(line_num), 32'(ml.n));
          chk("frame_done", 32'(frame_done), 32'(ml.fd));
          exp_bank = ml.b;
          exp_num  = ml.n;
        end
      end else begin
        chk("frame_done_idle", 32'(frame_done), 32'h0);
        chk("ready_bank_hold", 32'(ready_bank), 32'(exp_bank));
        chk("line_num_hold", 32'(line_num), 32'(exp_num));
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; vde = 1'b0; vsync = 1'b1; i_data = 8'h00;
    tick(); tick();
    mdl_in_frame = 1'b0; mdl_line = 0; mdl_err = 1'b0;
    wr_q.delete(); ln_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_o_data"}, o_data, 32'h0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'h0);
    chk({tag, "_line_ready"}, 32'(line_ready), 32'h0);
    chk({tag, "_ready_bank"}, 32'(ready_bank), 32'h0);
    chk({tag, "_line_num"}, 32'(line_num), 32'h0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    chk({tag, "_err_len"}, 32'(err_len), 32'h0);
  endtask

  task automatic vsync_fall();
    vde = 1'b0; vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    vsync = 1'b1; tick(); tick();
    mdl_in_frame = 1'b1;
    mdl_line = 0;
  endtask

  task automatic send_line(input int n, input int m);
    int np;
    model_line(n, m);
    np = (m >= 0) ? m : n;
    for (int k = 0; k < np; k++) begin
      vde = 1'b1; i_data = pix[k]; hsync = 1'b1; tick();
    end
    if (m >= 0) begin
      vde = 1'b0; vsync = 1'b0; tick();
      vsync = 1'b1;
    end
    vde = 1'b0; i_data = 8'h00; hsync = 1'b0; tick();
    hsync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic fill_seq(input logic [7:0] first);
    for (int k = 0; k < 16; k++) pix[k] = first + 8'(k);
  endtask

  initial begin
    int r, n, m;
    // Reset state
    do_reset();
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // Frame of two full lines, then a line outside any frame
    vsync_fall();
    fill_seq(8'h01); send_line(8, -1);
    chk("err_after_full_line", 32'(err_len), 32'(mdl_err));
    fill_seq(8'h11); send_line(8, -1);
    fill_seq(8'h31); send_line(8, -1);
    chk("err_after_frame", 32'(err_len), 32'h0);

    // Long line (drops extra pixels) then short line (partial word)
    vsync_fall();
    fill_seq(8'h01); send_line(10, -1);
    chk("err_long_line", 32'(err_len), 32'h1);
    fill_seq(8'h01); send_line(5, -1);
    chk("err_short_line", 32'(err_len), 32'h1);

    // vsync abort after 3 pixels, next line restarts at line 0 bank 0
    do_reset(); reset_n = 1'b1; tick();
    vsync_fall();
    fill_seq(8'hA1); send_line(8, 3);
    chk("err_abort", 32'(err_len), 32'h1);
    fill_seq(8'h21); send_line(8, -1);

    // reset_n mid-line discards everything; data without vsync is never written
    do_reset(); reset_n = 1'b1; tick();
    vsync_fall();
    fill_seq(8'h51);
    vde = 1'b1; i_data = pix[0]; tick();
    i_data = pix[1]; tick();
    do_reset();
    vde = 1'b0;
    check_all_zero("midline_reset");
    reset_n = 1'b1; tick();
    fill_seq(8'h61); send_line(8, -1);
    chk("err_no_frame", 32'(err_len), 32'h0);

    // Randomized traffic against the model
    vsync_fall();
    for (int it = 0; it < 60; it++) begin
      for (int k = 0; k < 16; k++) pix[k] = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r < 1) begin
        vsync_fall();
      end else if (r < 2) begin
        m = $urandom_range(1, DW + 2);
        send_line(DW, m);
      end else if (r < 7) begin
        send_line(DW, -1);
      end else begin
        n = $urandom_range(1, DW + 3);
        send_line(n, -1);
      end
      chk("err_len_rand", 32'(err_len), 32'(mdl_err));
    end

    // Drain
    for (int i = 0; i < 50 && (wr_q.size() != 0 || ln_q.size() != 0); i++) tick();
    chk("wr_queue_drained", 32'(wr_q.size()), 32'h0);
    chk("line_queue_drained", 32'(ln_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
